// File: rtl/gamma_lut_pipe.sv
// gamma_lut_pipe: streaming multi-channel gamma corrector.
// Each channel maps IN_W-bit pixels to OUT_W-bit values through a double-banked,
// runtime-loadable LUT. Software writes the shadow bank; a committed swap takes
// effect only at the next vsync rise so no frame is torn. After reset an init
// engine fills both banks with an identity curve.
// Optional feature: define GAMMA_READBACK_EN to add a shadow-bank readback port.
module gamma_lut_pipe #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 12,
  parameter int CH    = 3,
  localparam int CW   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                I_clk,
  input  logic                I_rst_n,
  input  logic                I_vs,
  input  logic                I_hs,
  input  logic                I_de,
  input  logic [CH*IN_W-1:0]  I_data,
  output logic                O_vs,
  output logic                O_hs,
  output logic                O_de,
  output logic [CH*OUT_W-1:0] O_data,
  input  logic                I_cfg_wr_en,
  input  logic [CW-1:0]       I_cfg_wr_ch,
  input  logic [IN_W-1:0]     I_cfg_wr_addr,
  input  logic [OUT_W-1:0]    I_cfg_wr_data,
  input  logic                I_cfg_commit,
  input  logic                I_bypass,
`ifdef GAMMA_READBACK_EN
  input  logic                I_cfg_rd_en,
  input  logic [CW-1:0]       I_cfg_rd_ch,
  input  logic [IN_W-1:0]     I_cfg_rd_addr,
  output logic [OUT_W-1:0]    O_cfg_rd_data,
  output logic                O_cfg_rd_valid,
`endif
  output logic                O_swap_pend,
  output logic                O_init_done
);

  localparam int              DEPTH = 1 << IN_W;
  localparam int              SH    = OUT_W - IN_W;
  localparam logic [IN_W-1:0] LAST  = '1;
  localparam logic [CW:0]     CH_L  = (CW+1)'(CH);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                 state;
  logic [IN_W-1:0]        init_addr;
  logic                   active;
  logic                   pending;
  logic                   bypass_q;
  logic                   run;
  logic                   commit_ok;
  logic                   wr_ok;

  logic                   vs_p1;
  logic                   hs_p1;
  logic                   de_p1;
  logic                   run_p1;
  logic                   vs_rise_p1;
  logic [CH*IN_W-1:0]     pix_p1;

  // Two banks per channel; each bank/channel memory has a single write port.
  logic [OUT_W-1:0]       lut [2][CH][DEPTH];

  // Identity curve: left-justify the input code in the output word.
  function automatic logic [OUT_W-1:0] identity(input logic [IN_W-1:0] a);
    return OUT_W'(a) << SH;
  endfunction

  assign run       = (state == S_RUN);
  assign commit_ok = run & I_cfg_commit;
  assign wr_ok     = run & I_rst_n & I_cfg_wr_en & ({1'b0, I_cfg_wr_ch} < CH_L);
  assign O_swap_pend = pending;

  // Init engine: sweep every address once after reset, then stay in RUN.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state       <= S_INIT;
      init_addr   <= '0;
      O_init_done <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          init_addr <= init_addr + 1'b1;
          if (init_addr == LAST) state <= S_RUN;
        end
        default: O_init_done <= 1'b1;
      endcase
    end
  end

  // Bank control: accept commits, swap banks and reload bypass at the frame boundary.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      active   <= 1'b0;
      pending  <= 1'b0;
      bypass_q <= 1'b0;
    end else if (vs_rise_p1) begin
      bypass_q <= I_bypass;
      if (pending || commit_ok) begin
        active  <= ~active;
        pending <= 1'b0;
      end
    end else if (commit_ok) begin
      pending <= 1'b1;
    end
  end

  // Table writes: identity into both banks during init, else software into the shadow bank.
  always_ff @(posedge I_clk) begin
    if (state == S_INIT) begin
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < CH; c++) begin
          lut[1'(b)][CW'(c)][init_addr] <= identity(init_addr);
        end
      end
    end else if (wr_ok) begin
      lut[~active][I_cfg_wr_ch][I_cfg_wr_addr] <= I_cfg_wr_data;
    end
  end

  // ---- stage 1: register syncs, frame-boundary pulse and LUT address ----
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      vs_p1      <= 1'b0;
      hs_p1      <= 1'b0;
      de_p1      <= 1'b0;
      run_p1     <= 1'b0;
      vs_rise_p1 <= 1'b0;
    end else begin
      vs_p1      <= I_vs;
      hs_p1      <= I_hs;
      de_p1      <= I_de;
      run_p1     <= run;
      vs_rise_p1 <= I_vs & ~vs_p1;
    end
  end

  // Pixel address register (data path, no reset).
  always_ff @(posedge I_clk) begin
    pix_p1 <= I_data;
  end

  // ---- stage 2: synchronous LUT read (or bypass) aligned with delayed syncs ----
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      O_vs   <= 1'b0;
      O_hs   <= 1'b0;
      O_de   <= 1'b0;
      O_data <= '0;
    end else begin
      O_vs <= vs_p1;
      O_hs <= hs_p1;
      O_de <= de_p1 & run_p1;
      for (int c = 0; c < CH; c++) begin
        if (!run_p1)
          O_data[c*OUT_W +: OUT_W] <= '0;
        else if (bypass_q)
          O_data[c*OUT_W +: OUT_W] <= identity(pix_p1[c*IN_W +: IN_W]);
        else
          O_data[c*OUT_W +: OUT_W] <= lut[active][CW'(c)][pix_p1[c*IN_W +: IN_W]];
      end
    end
  end

`ifdef GAMMA_READBACK_EN
  logic                   rd_vld_p1;
  logic                   rd_init_p1;
  logic [CW-1:0]          rd_ch_p1;
  logic [IN_W-1:0]        rd_addr_p1;

  // ---- readback stage 1: capture request and whether the table is still initialising ----
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      rd_vld_p1  <= 1'b0;
      rd_init_p1 <= 1'b0;
    end else begin
      rd_vld_p1  <= I_cfg_rd_en;
      rd_init_p1 <= ~run;
    end
  end

  // Readback address register (data path, no reset).
  always_ff @(posedge I_clk) begin
    rd_ch_p1   <= I_cfg_rd_ch;
    rd_addr_p1 <= I_cfg_rd_addr;
  end

  // ---- readback stage 2: read the shadow bank; zero while initialising or for a bad channel ----
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      O_cfg_rd_valid <= 1'b0;
      O_cfg_rd_data  <= '0;
    end else begin
      O_cfg_rd_valid <= rd_vld_p1;
      if (rd_vld_p1 && !rd_init_p1 && ({1'b0, rd_ch_p1} < CH_L))
        O_cfg_rd_data <= lut[~active][rd_ch_p1][rd_addr_p1];
      else
        O_cfg_rd_data <= '0;
    end
  end
`endif

endmodule
